// File: rtl/dh_key_mod_cipher.sv
// Diffie-Hellman encrypt/verify stage: reduces exp mod p bit-serially, authenticates
// the peer tag against the derived key and emits the ciphertext on success.
module dh_key_mod_cipher #(
  parameter int DW = 32,
  parameter int EW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [EW-1:0] exp,
  input  logic [DW-1:0] p,
  input  logic [DW-1:0] r1,
  input  logic [DW-1:0] r2,
  input  logic [DW-1:0] c1,
  output logic          busy,
  output logic          done,
  output logic          true,
  output logic          err,
  output logic [DW-1:0] c2
);

  localparam int CW = (EW > 1) ? $clog2(EW) : 1;
  localparam logic [DW-1:0] C2_INIT = DW'(4'hF);

  typedef enum logic [1:0] {IDLE, REDUCE, CHECK, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [EW-1:0] exp_q;
  logic [DW-1:0] p_q;
  logic [DW-1:0] r1_q;
  logic [DW-1:0] r2_q;
  logic [DW-1:0] c1_q;
  logic [DW:0]   rem;
  logic [CW-1:0] cnt;
  logic [DW:0]   t;
  logic [DW:0]   t_red;
  logic [DW-1:0] k;
  logic          accept;
  logic          pass;

  // Restoring reduction step: shift in the next exp bit, subtract p when it fits.
  always_comb begin
    accept = (state == IDLE) && start;
    t      = {rem[DW-1:0], exp_q[cnt]};
    t_red  = (t >= {1'b0, p_q}) ? (t - {1'b0, p_q}) : t;
    k      = rem[DW-1:0];
    pass   = ((k ^ c1_q) == r2_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:   if (start) state_next = (p == '0) ? DONE : REDUCE;
      REDUCE: begin
        busy = 1'b1;
        if (cnt == '0) state_next = CHECK;
      end
      CHECK:  begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE:   begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, remainder iteration and the held result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q <= '0;
      p_q   <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      c1_q  <= '0;
      rem   <= '0;
      cnt   <= '0;
      true  <= 1'b0;
      err   <= 1'b0;
      c2    <= C2_INIT;
    end else if (accept) begin
      exp_q <= exp;
      p_q   <= p;
      r1_q  <= r1;
      r2_q  <= r2;
      c1_q  <= c1;
      rem   <= '0;
      cnt   <= CW'(EW - 1);
      true  <= 1'b0;
      err   <= (p == '0);
      c2    <= (p == '0) ? '0 : C2_INIT;
    end else if (state == REDUCE) begin
      rem <= t_red;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end else if (state == CHECK) begin
      true <= pass;
      c2   <= pass ? (k ^ r1_q) : '0;
    end
  end

endmodule

// File: tb/tb_dh_key_mod_cipher.sv
// Self-checking bench for dh_key_mod_cipher: an edge-indexed transaction model
// predicts every output on every cycle, plus directed cases with literal results.
module tb_dh_key_mod_cipher;

  localparam int DW = 32;
  localparam int EW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [EW-1:0] exp = '0;
  logic [DW-1:0] p = '0;
  logic [DW-1:0] r1 = '0;
  logic [DW-1:0] r2 = '0;
  logic [DW-1:0] c1 = '0;
  logic          busy;
  logic          done;
  logic          pass_o;
  logic          err;
  logic [DW-1:0] c2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  dh_key_mod_cipher #(.DW(DW), .EW(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .exp(exp), .p(p), .r1(r1), .r2(r2),
    .c1(c1), .busy(busy), .done(done), .true(pass_o), .err(err), .c2(c2)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_key(input logic [EW-1:0] e, input logic [DW-1:0] m);
    logic [EW-1:0] r;
    r = (m == '0) ? '0 : (e % {{(EW-DW){1'b0}}, m});
    return r[DW-1:0];
  endfunction

  // Transaction model: n counts clock edges since reset; a request is taken
  // when no operation is in flight, and its results appear at fixed edge offsets.
  int            n = 0;
  bit            have_op = 0;
  bit            zero_op = 0;
  int            a_e = 0;
  int            done_e = 0;
  logic          fin_true = 1'b0;
  logic          fin_err = 1'b0;
  logic [DW-1:0] fin_c2 = '0;

  always @(posedge clk or negedge rst) begin : model
    int e;
    logic [DW-1:0] kk;
    if (!rst) begin
      n       <= 0;
      have_op <= 0;
    end else begin
      e = n + 1;
      n <= e;
      if (start && (!have_op || e >= done_e + 2)) begin
        kk = model_key(exp, p);
        have_op <= 1;
        a_e     <= e;
        zero_op <= (p == '0);
        done_e  <= (p == '0) ? e : e + EW + 1;
        if (p == '0) begin
          fin_true <= 1'b0;
          fin_err  <= 1'b1;
          fin_c2   <= '0;
        end else if ((kk ^ c1) == r2) begin
          fin_true <= 1'b1;
          fin_err  <= 1'b0;
          fin_c2   <= kk ^ r1;
        end else begin
          fin_true <= 1'b0;
          fin_err  <= 1'b0;
          fin_c2   <= '0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic          e_busy, e_done, e_true, e_err;
    logic [DW-1:0] e_c2;
    if (chk_en) begin
      e_busy = 1'b0;
      e_done = 1'b0;
      e_true = 1'b0;
      e_err  = 1'b0;
      e_c2   = 32'h0000000F;
      if (rst && have_op) begin
        e_busy = !zero_op && (n >= a_e) && (n <= a_e + EW);
        e_done = (n == done_e);
        if (n >= done_e) begin
          e_true = fin_true;
          e_err  = fin_err;
          e_c2   = fin_c2;
        end
      end
      check_output("busy", busy, e_busy);
      check_output("done", done, e_done);
      check_output("true", pass_o, e_true);
      check_output("err", err, e_err);
      check_output("c2", c2, e_c2);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [EW-1:0] e, input logic [DW-1:0] pp,
                                input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                                input logic [DW-1:0] b1);
    exp   = e;
    p     = pp;
    r1    = a1;
    r2    = a2;
    c1    = b1;
    start = 1'b1;
  endtask

  task automatic scramble();
    start = 1'b0;
    exp   = {$urandom, $urandom};
    p     = $urandom;
    r1    = $urandom;
    r2    = $urandom;
    c1    = $urandom;
  endtask

  // Counts edges until done is seen; the edge that samples start is edge 1.
  task automatic wait_done(output int lat);
    bit got;
    lat = 0;
    got = 0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      got = done;
      #2;
      scramble();
    end
    if (!got) check_output("done_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int seen;

    check_output("model_k_small", model_key(64'd100, 32'd23), 32'd8);
    check_output("model_k_wide", model_key(64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFB), 32'd24);
    check_output("model_k_div", model_key(64'd46, 32'd23), 32'd0);

    rst = 1'b0;
    tick();
    tick();
    chk_en = 1;
    check_output("reset_c2", c2, 32'h0000000F);
    check_output("reset_busy", busy, 0);
    rst = 1'b1;
    tick();

    $display("[TB] pass case");
    apply_stimulus(64'd100, 32'd23, 32'h30, 32'd13, 32'd5);
    wait_done(lat);
    check_output("pass_latency", lat, 66);
    tick();
    check_output("pass_true", pass_o, 1);
    check_output("pass_c2", c2, 32'h00000038);
    check_output("pass_err", err, 0);

    $display("[TB] mismatch case");
    apply_stimulus(64'd100, 32'd23, 32'h30, 32'd12, 32'd5);
    wait_done(lat);
    tick();
    check_output("mismatch_true", pass_o, 0);
    check_output("mismatch_c2", c2, 32'h00000000);

    $display("[TB] wide operands");
    apply_stimulus(64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFB, 32'd0, 32'd24, 32'd0);
    wait_done(lat);
    tick();
    check_output("wide_true", pass_o, 1);
    check_output("wide_c2", c2, 32'h00000018);

    $display("[TB] zero modulus");
    apply_stimulus(64'd12345, 32'd0, 32'h55, 32'h66, 32'h77);
    wait_done(lat);
    check_output("zero_latency", lat, 1);
    check_output("zero_err", err, 1);
    check_output("zero_true", pass_o, 0);
    check_output("zero_c2", c2, 32'h0);
    tick();

    $display("[TB] divisible case");
    apply_stimulus(64'd46, 32'd23, 32'h0000ABCD, 32'd7, 32'd7);
    wait_done(lat);
    tick();
    check_output("div_true", pass_o, 1);
    check_output("div_c2", c2, 32'h0000ABCD);

    $display("[TB] busy protection");
    apply_stimulus(64'd100, 32'd23, 32'h30, 32'd13, 32'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      scramble();
    end
    apply_stimulus(64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFB, 32'd0, 32'd24, 32'd0);
    tick();
    scramble();
    wait_done(lat);
    check_output("busy_latency", lat + 11, 66);
    tick();
    check_output("busy_c2", c2, 32'h00000038);
    apply_stimulus(64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFB, 32'd0, 32'd24, 32'd0);
    wait_done(lat);
    tick();
    check_output("busy_next_c2", c2, 32'h00000018);

    $display("[TB] reset mid-reduce");
    apply_stimulus(64'd100, 32'd23, 32'h30, 32'd13, 32'd5);
    for (int i = 0; i < 30; i++) begin
      tick();
      scramble();
    end
    rst = 1'b0;
    tick();
    check_output("abort_c2", c2, 32'h0000000F);
    check_output("abort_busy", busy, 0);
    check_output("abort_true", pass_o, 0);
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) seen++;
      #2;
    end
    check_output("abort_no_done", seen, 0);
    apply_stimulus(64'd100, 32'd23, 32'h30, 32'd13, 32'd5);
    wait_done(lat);
    check_output("fresh_latency", lat, 66);
    tick();
    check_output("fresh_c2", c2, 32'h00000038);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
